run_sequencer: RTL and testbench

Program-run controller for the single-cycle 9-bit core. It takes a host start request, holds the fetch unit in init for a fixed number of cycles, loads the start PC, and enables the core until it halts or a watchdog expires. It counts executed cycles and arbitrates the shared data-memory port between the host (preload/readback) and the core. It sits between the testbench/host and the fetch unit, control, and data memory at top level.

---
 rtl/run_sequencer.sv | 133 +++++++++++++
 tb/tb_run_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// Run controller for the single-cycle 9-bit core.
// Sequences a host start request through init, run and done. It counts run
// cycles, enforces an optional watchdog, and shares the data-memory port
// between the host and the core.
module run_sequencer #(
    parameter int INIT_CYCLES = 2,      // 1..15 cycles of core_init after accept
    parameter int CNT_W       = 16,     // cycle counter width
    parameter int MAX_CYCLES  = 65535   // watchdog limit in RUN cycles, 0 = off
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             req_start,
    input  logic [7:0]       start_addr,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             core_init,
    output logic [7:0]       core_target,
    output logic             core_run,
    input  logic             core_halt,
    output logic [CNT_W-1:0] cycle_count,
    input  logic             host_mem_req,
    input  logic             host_mem_we,
    input  logic [7:0]       host_mem_addr,
    input  logic [7:0]       host_mem_wdata,
    output logic             host_mem_gnt,
    input  logic             core_mem_we,
    input  logic [7:0]       core_mem_addr,
    input  logic [7:0]       core_mem_wdata,
    output logic             dm_we,
    output logic [7:0]       dm_addr,
    output logic [7:0]       dm_wdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [3:0]       INIT_LOAD = 4'(INIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    // Count value seen on the final permitted RUN cycle.
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(MAX_CYCLES - 1);
    localparam bit               WD_EN     = (MAX_CYCLES != 0);

    state_t     state;
    logic [3:0] init_cnt;

    // Run sequencing FSM; every output it drives is registered alongside the state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            init_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            core_init   <= 1'b1;
            core_target <= '0;
            core_run    <= 1'b0;
            cycle_count <= '0;
        end else begin
            // NOTE: non-blocking assignments here let every register update from
            // the same pre-edge values, so statement order cannot change behaviour.
            case (state)
                S_IDLE: begin
                    if (req_start) begin
                        core_target <= start_addr;
                        cycle_count <= '0;
                        timeout     <= 1'b0;
                        init_cnt    <= INIT_LOAD;
                        busy        <= 1'b1;
                        state       <= S_INIT;
                    end
                end
                S_INIT: begin
                    init_cnt <= init_cnt - 4'd1;
                    // Leaving on the count of one makes INIT last exactly INIT_CYCLES.
                    if (init_cnt == 4'd1) begin
                        core_init <= 1'b0;
                        core_run  <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cycle_count != CNT_SAT) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                    // Halt takes priority, so a coincident watchdog hit leaves timeout low.
                    if (core_halt || (WD_EN && cycle_count == WD_LAST)) begin
                        timeout   <= !core_halt;
                        core_run  <= 1'b0;
                        core_init <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Waiting for req_start to drop guarantees a low cycle before re-accept.
                    if (!req_start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign host_mem_gnt = host_mem_req & ~core_run;

    // Data-memory port mux: the core owns it in RUN, the host otherwise.
    always_comb begin
        // NOTE: defaults first on every path keep this block purely combinational.
        dm_we    = 1'b0;
        dm_addr  = host_mem_addr;
        dm_wdata = host_mem_wdata;
        if (core_run) begin
            dm_we    = core_mem_we;
            dm_addr  = core_mem_addr;
            dm_wdata = core_mem_wdata;
        end else if (host_mem_gnt) begin
            dm_we = host_mem_we;
        end
        // Memory must never see a write while reset is held, whoever requests it.
        if (!RST_N) begin
            dm_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: a spec-level model checked every
// cycle, plus directed scenarios pinned with hand-computed literals.
module tb_run_sequencer;

    localparam int INIT_CYCLES = 2;
    localparam int CNT_W       = 16;
    localparam int MAX_CYCLES  = 8;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             req_start;
    logic [7:0]       start_addr;
    logic             busy, done, timeout, core_init, core_run;
    logic [7:0]       core_target;
    logic             core_halt;
    logic [CNT_W-1:0] cycle_count;
    logic             host_mem_req, host_mem_we;
    logic [7:0]       host_mem_addr, host_mem_wdata;
    logic             host_mem_gnt;
    logic             core_mem_we;
    logic [7:0]       core_mem_addr, core_mem_wdata;
    logic             dm_we;
    logic [7:0]       dm_addr, dm_wdata;

    run_sequencer #(
        .INIT_CYCLES(INIT_CYCLES),
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .req_start     (req_start),
        .start_addr    (start_addr),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .core_init     (core_init),
        .core_target   (core_target),
        .core_run      (core_run),
        .core_halt     (core_halt),
        .cycle_count   (cycle_count),
        .host_mem_req  (host_mem_req),
        .host_mem_we   (host_mem_we),
        .host_mem_addr (host_mem_addr),
        .host_mem_wdata(host_mem_wdata),
        .host_mem_gnt  (host_mem_gnt),
        .core_mem_we   (core_mem_we),
        .core_mem_addr (core_mem_addr),
        .core_mem_wdata(core_mem_wdata),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata)
    );

    always #5 CLK = ~CLK;

    int vectors   = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases follow the specification's four named states.
    localparam int PH_IDLE = 0, PH_INIT = 1, PH_RUN = 2, PH_DONE = 3;

    int          m_phase;
    int          m_init_left;
    int          m_count;
    bit          m_timeout;
    logic [7:0]  m_target;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_phase     = PH_IDLE;
            m_init_left = 0;
            m_count     = 0;
            m_timeout   = 0;
            m_target    = 8'h00;
        end else begin
            case (m_phase)
                PH_IDLE: if (req_start) begin
                    m_target    = start_addr;
                    m_count     = 0;
                    m_timeout   = 0;
                    m_init_left = INIT_CYCLES;
                    m_phase     = PH_INIT;
                end
                PH_INIT: begin
                    m_init_left = m_init_left - 1;
                    if (m_init_left == 0) m_phase = PH_RUN;
                end
                PH_RUN: begin
                    if (m_count < (1 << CNT_W) - 1) m_count = m_count + 1;
                    if (core_halt) begin
                        m_phase = PH_DONE;
                    end else if (MAX_CYCLES != 0 && m_count >= MAX_CYCLES) begin
                        m_timeout = 1;
                        m_phase   = PH_DONE;
                    end
                end
                default: if (!req_start) m_phase = PH_IDLE;
            endcase
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge CLK) begin
        bit in_run;
        in_run = (m_phase == PH_RUN);
        check("busy",        32'(busy),        32'(m_phase == PH_INIT || m_phase == PH_RUN));
        check("done",        32'(done),        32'(m_phase == PH_DONE));
        check("timeout",     32'(timeout),     32'(m_timeout));
        check("core_init",   32'(core_init),   32'(!in_run));
        check("core_run",    32'(core_run),    32'(in_run));
        check("core_target", 32'(core_target), 32'(m_target));
        check("cycle_count", 32'(cycle_count), 32'(m_count));
        check("host_gnt",    32'(host_mem_gnt), 32'(host_mem_req && !in_run));
        check("dm_we",       32'(dm_we),
              32'(RST_N && (in_run ? core_mem_we : (host_mem_req && host_mem_we))));
        if (in_run) begin
            check("dm_addr_core",  32'(dm_addr),  32'(core_mem_addr));
            check("dm_wdata_core", 32'(dm_wdata), 32'(core_mem_wdata));
        end else if (host_mem_req) begin
            check("dm_addr_host",  32'(dm_addr),  32'(host_mem_addr));
            check("dm_wdata_host", 32'(dm_wdata), 32'(host_mem_wdata));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait (bounded) until done rises; counts RUN cycles seen on the way.
    task automatic wait_done(input string name, output int run_cycles);
        int n;
        run_cycles = 0;
        n = 0;
        while (!done && n < 60) begin
            if (core_run) run_cycles++;
            tick();
            n++;
        end
        if (!done) check({name, "_wait_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        #20000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int init_cycles_seen;
        int run_cycles;

        RST_N = 1'b0;
        req_start = 0; start_addr = 0; core_halt = 0;
        host_mem_req = 0; host_mem_we = 0; host_mem_addr = 0; host_mem_wdata = 0;
        core_mem_we = 0; core_mem_addr = 0; core_mem_wdata = 0;

        // Reset values.
        #12;
        check("rst_busy",      32'(busy),        32'd0);
        check("rst_core_init", 32'(core_init),   32'd1);
        check("rst_core_run",  32'(core_run),    32'd0);
        check("rst_count",     32'(cycle_count), 32'd0);
        #10 RST_N = 1'b1;
        tick();

        // Host write in IDLE.
        host_mem_req = 1; host_mem_we = 1; host_mem_addr = 8'h20; host_mem_wdata = 8'hAB;
        core_halt = 1;  // halt outside RUN must be ignored
        #1;
        check("idle_gnt",   32'(host_mem_gnt), 32'd1);
        check("idle_dm_we", 32'(dm_we),        32'd1);
        check("idle_addr",  32'(dm_addr),      32'h20);
        check("idle_wdata", 32'(dm_wdata),     32'hAB);
        tick();
        core_halt = 0;

        // Scenario 1: start at 0x10, halt on 5th RUN cycle.
        start_addr = 8'h10; req_start = 1;
        tick();
        req_start = 0;  // dropping during INIT is ignored
        check("s1_target", 32'(core_target), 32'h10);
        init_cycles_seen = 0;
        n = 0;
        while (!core_run && n < 20) begin
            if (core_init) init_cycles_seen++;
            tick();
            n++;
        end
        check("s1_init_len", 32'(init_cycles_seen), 32'd2);
        // Same host request during RUN: port belongs to the core.
        core_mem_we = 1; core_mem_addr = 8'h33; core_mem_wdata = 8'h5A;
        #1;
        check("run_gnt",   32'(host_mem_gnt), 32'd0);
        check("run_dm_we", 32'(dm_we),        32'd1);
        check("run_addr",  32'(dm_addr),      32'h33);
        check("run_wdata", 32'(dm_wdata),     32'h5A);
        repeat (4) tick();
        core_halt = 1;
        tick();
        core_halt = 0; core_mem_we = 0;
        check("s1_done",    32'(done),        32'd1);
        check("s1_count",   32'(cycle_count), 32'd5);
        check("s1_timeout", 32'(timeout),     32'd0);
        tick();  // req_start already low: back to IDLE
        host_mem_req = 0; host_mem_we = 0;

        // Scenario 3: watchdog at 8 cycles.
        req_start = 1;
        tick();
        req_start = 0;
        wait_done("s3", run_cycles);
        check("s3_run_cycles", 32'(run_cycles),  32'd8);
        check("s3_timeout",    32'(timeout),     32'd1);
        check("s3_count",      32'(cycle_count), 32'd8);
        tick();

        // Scenario 4: halt coincides with watchdog; req_start held through DONE.
        req_start = 1;
        tick();
        check("s4_timeout_cleared", 32'(timeout), 32'd0);
        n = 0;
        while (!core_run && n < 20) begin tick(); n++; end
        repeat (7) tick();
        core_halt = 1;
        tick();
        core_halt = 0;
        check("s4_done",    32'(done),        32'd1);
        check("s4_count",   32'(cycle_count), 32'd8);
        check("s4_timeout", 32'(timeout),     32'd0);

        // Scenario 5: held request does not restart; a one-cycle drop does.
        repeat (3) tick();
        check("s5_hold_done", 32'(done), 32'd1);
        check("s5_hold_busy", 32'(busy), 32'd0);
        req_start = 0;
        tick();
        req_start = 1;
        tick();
        check("s5_restart_busy",  32'(busy),        32'd1);
        check("s5_restart_count", 32'(cycle_count), 32'd0);
        req_start = 0;

        // Scenario 6: asynchronous reset mid-RUN.
        n = 0;
        while (!core_run && n < 20) begin tick(); n++; end
        repeat (2) tick();
        core_mem_we = 1; host_mem_req = 1; host_mem_we = 1;
        #2 RST_N = 1'b0;
        #1;
        check("s6_core_run",  32'(core_run),  32'd0);
        check("s6_core_init", 32'(core_init), 32'd1);
        check("s6_dm_we",     32'(dm_we),     32'd0);
        check("s6_count",     32'(cycle_count), 32'd0);
        #3 RST_N = 1'b1;
        core_mem_we = 0; host_mem_req = 0; host_mem_we = 0;
        tick();
        tick();
        check("s6_idle_busy", 32'(busy), 32'd0);
        check("s6_idle_done", 32'(done), 32'd0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
